// File: rtl/mux_lut_gate_unit_pkg.sv
// Shared truth-table constants for the LUT gate unit.
// A table is indexed by {a,b}: bit 0 is a=0,b=0 ... bit 3 is a=1,b=1.
package mux_lut_gate_unit_pkg;

  localparam int TT_W = 4;

  typedef logic [TT_W-1:0] tt_t;

  localparam tt_t TT_AND   = 4'b1000;
  localparam tt_t TT_OR    = 4'b1110;
  localparam tt_t TT_XOR   = 4'b0110;
  localparam tt_t TT_NAND  = 4'b0111;
  localparam tt_t TT_NOTA  = 4'b0011;
  localparam tt_t TT_PASSB = 4'b1010;

  // Table loaded at reset.
  localparam tt_t TT_RESET = TT_AND;

endpackage

// File: rtl/mux_lut_gate_unit_mux_41_bit.sv
// Single-lane 4:1 selector built from three 2:1 muxes.
// The first level picks on b, the second level picks on a, which together
// select tt[{a,b}].
module mux_41_bit
  import mux_lut_gate_unit_pkg::*;
(
  input  tt_t  tt_i,
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  logic lo_sel;  // candidates with a=0
  logic hi_sel;  // candidates with a=1

  // First level: b chooses within each a-half of the table.
  always_comb begin
    lo_sel = b_i ? tt_i[1] : tt_i[0];
    hi_sel = b_i ? tt_i[3] : tt_i[2];
  end

  // Second level: a chooses between the two halves.
  assign y_o = a_i ? hi_sel : lo_sel;

endmodule

// File: rtl/mux_lut_gate_unit.sv
// Per-lane programmable 2-input gate with a one-deep valid/ready output
// register and a saturating count of completed output handshakes.
module mux_lut_gate_unit
  import mux_lut_gate_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_tt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       tt,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  tt_t              tt_q, tt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lane_res;
  logic             in_hs, out_hs;

  // The output register can take a new word when empty or being drained.
  assign in_ready = !vld_q || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = vld_q && out_ready;

  // Lanes always see the registered table, so a same-cycle cfg write only
  // affects operands accepted on later cycles.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    mux_41_bit u_mux (
      .tt_i (tt_q),
      .a_i  (a[i]),
      .b_i  (b[i]),
      .y_o  (lane_res[i])
    );
  end

  // Next-state: table load, output register fill/drain, saturating counter.
  always_comb begin
    tt_d  = tt_q;
    y_d   = y_q;
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (cfg_we) tt_d = cfg_tt;
    if (in_hs) begin
      y_d   = lane_res;
      vld_d = 1'b1;
    end else if (out_hs) begin
      vld_d = 1'b0;
    end
    if (out_hs && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // State registers; reset wins over any handshake or table write.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q  <= TT_RESET;
      y_q   <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      tt_q  <= tt_d;
      y_q   <= y_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign y         = y_q;
  assign tt        = tt_q;
  assign op_count  = cnt_q;

endmodule

// File: doc/mux_lut_gate_unit.md
MUX_LUT_GATE_UNIT -- requirements
Module: mux_lut_gate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bit lanes per operand.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; synchronous and active-high.
REQ-005 The block SHALL have port cfg_we, input, 1 bit, the truth-table write strobe.
REQ-006 The block SHALL have port cfg_tt, input, 4 bits, the new truth table, indexed by {a,b}.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the operands are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept operands.
REQ-009 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-010 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning y is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning the downstream consumer accepts y.
REQ-013 The block SHALL have port y, output, WIDTH bits, the registered result.
REQ-014 The block SHALL have port tt, output, 4 bits, the current truth table.
REQ-015 The block SHALL have port op_count, output, CNT_W bits, the number of completed output handshakes.

Function
REQ-016 For each lane i, the result bit SHALL equal tt[{a[i],b[i]}], selected by a 4:1 mux built from 2:1 muxes: level 1 selects on b[i], level 2 selects on a[i].
REQ-017 An input handshake SHALL occur when in_valid and in_ready are both high; an output handshake SHALL occur when out_valid and out_ready are both high.
REQ-018 in_ready SHALL equal (!out_valid || out_ready), so there are no bubbles at full throughput.
REQ-019 On an input handshake, y SHALL load the result and out_valid SHALL be set; the latency is exactly 1 cycle.
REQ-020 On an output handshake with no input handshake in the same cycle, out_valid SHALL clear; y SHALL hold its value.
REQ-021 While out_valid is high and out_ready is low, y and out_valid SHALL hold.
REQ-022 On cfg_we, tt SHALL load cfg_tt at the clock edge.
REQ-023 An input handshake in the same cycle as cfg_we SHALL use the old tt; results already in y SHALL NOT change.
REQ-024 op_count SHALL increment by 1 on each output handshake and saturate at all-ones, with no wrap.
REQ-025 Combinational paths SHALL be limited to in_ready, which depends only on out_valid and out_ready; y SHALL NOT be combinational from a or b.

Reset
REQ-026 When rst is high at a clock edge, the block SHALL set out_valid=0, y=0, op_count=0 and tt=4'b1000 (AND).
REQ-027 Reset SHALL take priority over cfg_we and over any handshake in the same cycle; an in-flight result SHALL be discarded.
REQ-028 While rst is high, in_ready SHALL still follow REQ-018; a handshake in that cycle SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOTA=4'b0011, TT_PASSB=4'b1010.
REQ-030 The shared package SHALL also hold the reset-default table, set to TT_AND.
REQ-031 One sub-module, mux_41_bit, SHALL implement the per-lane 4:1 selection from three 2:1 muxes.
REQ-032 The top level SHALL instantiate mux_41_bit WIDTH times through a generate loop.

Verification
REQ-033 Reset check: assert rst, then a=8'hF0, b=8'hCC, in_valid=1, out_ready=1 -> y=8'hC0 one cycle after the handshake; op_count=1 one cycle after the output handshake.
REQ-034 Truth-table sweep: apply cfg_tt = TT_OR, TT_XOR, TT_NAND, TT_NOTA in turn with a=F0, b=CC -> y = FC, 3C, 3F, 0F respectively.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first accept; y stays stable; releasing out_ready transfers both words in order.
REQ-036 Config collision: pulse cfg_we with cfg_tt=TT_XOR in the same cycle as an accept under AND, with a=FF, b=0F -> that result is 0F; the next identical input gives F0.
REQ-037 Counter saturation: with CNT_W=4, perform 20 output handshakes -> op_count=4'hF.
REQ-038 Mid-stream reset: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, y=0, tt=TT_AND.
